reduction_accumulator: RTL and testbench

//  Consumes the reduction packets that the local ejection crossbar separates out, one per cycle.

---
 rtl/reduction_accumulator.sv | 177 +++++++++++++++++
 tb/tb_reduction_accumulator.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reduction_accumulator.sv
// Per-index reduction accumulator: sums payload/weight of reduction packets in a
// table and emits one combined packet when the configured fan-in count is reached.
module reduction_accumulator #(
  parameter int unsigned DataWidth          = 256,
  parameter int unsigned ReductionBitPos    = 254,
  parameter int unsigned PayloadLen         = 128,
  parameter int unsigned IndexPos           = 128,
  parameter int unsigned IndexWidth         = 16,
  parameter int unsigned WeightPos          = 144,
  parameter int unsigned WeightWidth        = 8,
  parameter int unsigned ExitPos            = 160,
  parameter int unsigned ExitWidth          = 4,
  parameter int unsigned ReductionTablesize = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DataWidth-1:0]  in_data,
  output logic                  in_avail,
  input  logic                  cfg_we,
  input  logic [IndexWidth-1:0] cfg_index,
  input  logic [2:0]            cfg_expect,
  input  logic [ExitWidth-1:0]  cfg_dst,
  output logic                  cfg_done,
  input  logic                  in_pipeline_stall,
  output logic [DataWidth-1:0]  out_data,
  output logic                  err_unconfigured
);

  localparam int unsigned TblAw = (ReductionTablesize > 1) ? $clog2(ReductionTablesize) : 1;

  typedef struct packed {
    logic [2:0]             expct;
    logic [2:0]             arrived;
    logic [ExitWidth-1:0]   dst;
    logic [IndexWidth-1:0]  index;
    logic [WeightWidth-1:0] weight;
    logic [PayloadLen-1:0]  payload;
  } entry_t;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e               state_q, state_d;
  logic [TblAw-1:0]     ptr_q, ptr_d;

  entry_t               mem [ReductionTablesize];
  logic                 mem_we;
  logic [TblAw-1:0]     mem_wa;
  entry_t               mem_wd;

  logic                 rd_vld_q;
  logic [DataWidth-1:0] rd_pkt_q;
  entry_t               rd_ent_q;
  logic                 wb_vld_q;
  logic [TblAw-1:0]     wb_idx_q;
  entry_t               wb_ent_q;
  logic [DataWidth-1:0] out_q;
  logic                 err_q;
  logic                 cfg_done_q;

  logic                 advance, accept, cfg_fire;
  logic [TblAw-1:0]     in_idx, rd_idx;
  entry_t               cur, new_ent, cfg_ent;
  logic [2:0]           arr_n;
  logic [WeightWidth-1:0] w_n;
  logic [PayloadLen-1:0]  p_n;
  logic                 ac_unconf, ac_done, ac_wr;
  logic [DataWidth-1:0] ac_out;

  assign advance  = ~in_pipeline_stall;
  assign in_avail = (state_q == ST_RUN) & ~in_pipeline_stall & ~cfg_we;
  assign accept   = in_avail & in_data[DataWidth-1] & in_data[ReductionBitPos];
  assign in_idx   = in_data[IndexPos +: TblAw];
  assign rd_idx   = rd_pkt_q[IndexPos +: TblAw];

  // Config waits for an empty pipe so no in-flight or forwarded entry can go stale.
  assign cfg_fire = (state_q == ST_RUN) & cfg_we & ~cfg_done_q & ~rd_vld_q & ~wb_vld_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == TblAw'(ReductionTablesize - 1)) state_d = ST_RUN;
    end
  end

  // The previous AC wrote at the same edge the RAM was read, so its result is newer.
  always_comb begin
    cur       = (wb_vld_q && (wb_idx_q == rd_idx)) ? wb_ent_q : rd_ent_q;
    arr_n     = cur.arrived + 3'd1;
    w_n       = cur.weight + rd_pkt_q[WeightPos +: WeightWidth];
    p_n       = cur.payload + rd_pkt_q[PayloadLen-1:0];
    ac_unconf = rd_vld_q && (cur.expct == 3'd0);
    ac_done   = rd_vld_q && (cur.expct != 3'd0) && (arr_n == cur.expct);
    ac_wr     = rd_vld_q && (cur.expct != 3'd0) && advance;
    new_ent   = cur;
    ac_out    = '0;
    if (ac_done) begin
      new_ent.arrived = '0;
      new_ent.weight  = '0;
      new_ent.payload = '0;
      ac_out = rd_pkt_q;
      ac_out[ExitPos +: ExitWidth]     = cur.dst;
      ac_out[WeightPos +: WeightWidth] = w_n;
      ac_out[PayloadLen-1:0]           = p_n;
    end else begin
      new_ent.arrived = arr_n;
      new_ent.weight  = w_n;
      new_ent.payload = p_n;
      if (ac_unconf) ac_out = rd_pkt_q;
    end
  end

  always_comb begin
    cfg_ent       = '0;
    cfg_ent.expct = cfg_expect;
    cfg_ent.dst   = cfg_dst;
    cfg_ent.index = cfg_index;
    mem_we        = 1'b0;
    mem_wa        = '0;
    mem_wd        = '0;
    if (state_q == ST_INIT) begin
      mem_we = 1'b1;
      mem_wa = ptr_q;
    end else if (cfg_fire) begin
      mem_we = 1'b1;
      mem_wa = cfg_index[TblAw-1:0];
      mem_wd = cfg_ent;
    end else if (ac_wr) begin
      mem_we = 1'b1;
      mem_wa = rd_idx;
      mem_wd = new_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    if (accept) rd_ent_q <= mem[in_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      rd_vld_q   <= 1'b0;
      rd_pkt_q   <= '0;
      wb_vld_q   <= 1'b0;
      wb_idx_q   <= '0;
      wb_ent_q   <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cfg_done_q <= cfg_fire;
      if (advance) begin
        rd_vld_q <= accept;
        if (accept) rd_pkt_q <= in_data;
        wb_vld_q <= ac_wr;
        if (ac_wr) begin
          wb_idx_q <= rd_idx;
          wb_ent_q <= new_ent;
        end
        out_q <= ac_out;
        err_q <= ac_unconf;
      end else begin
        err_q <= 1'b0;
      end
    end
  end

  assign out_data         = out_q;
  assign err_unconfigured = err_q;
  assign cfg_done         = cfg_done_q;

endmodule

// File: tb/tb_reduction_accumulator.sv
// Directed bench for reduction_accumulator with hand-computed expected packets.
module tb_reduction_accumulator;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [255:0] in_data = '0;
  logic         in_avail;
  logic         cfg_we = 1'b0;
  logic [15:0]  cfg_index = '0;
  logic [2:0]   cfg_expect = '0;
  logic [3:0]   cfg_dst = '0;
  logic         cfg_done;
  logic         in_pipeline_stall = 1'b0;
  logic [255:0] out_data;
  logic         err_unconfigured;

  int vectors = 0;
  int miscompares = 0;

  reduction_accumulator #(
    .DataWidth(256), .ReductionBitPos(254), .PayloadLen(128),
    .IndexPos(128), .IndexWidth(16), .WeightPos(144), .WeightWidth(8),
    .ExitPos(160), .ExitWidth(4), .ReductionTablesize(256)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_avail(in_avail),
    .cfg_we(cfg_we), .cfg_index(cfg_index), .cfg_expect(cfg_expect),
    .cfg_dst(cfg_dst), .cfg_done(cfg_done),
    .in_pipeline_stall(in_pipeline_stall), .out_data(out_data),
    .err_unconfigured(err_unconfigured)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mkpkt(input logic [15:0] idx, input logic [7:0] w,
                                         input logic [127:0] p);
    logic [255:0] d;
    d = '0;
    d[255] = 1'b1;
    d[254] = 1'b1;
    d[200:193] = 8'h3C;
    d[163:160] = 4'hF;
    d[159:152] = 8'hA5;
    d[151:144] = w;
    d[143:128] = idx;
    d[127:0]   = p;
    return d;
  endfunction

  function automatic logic [255:0] mkout(input logic [15:0] idx, input logic [7:0] w,
                                         input logic [127:0] p, input logic [3:0] dst);
    logic [255:0] d;
    d = mkpkt(idx, w, p);
    d[163:160] = dst;
    return d;
  endfunction

  task automatic cfg_write(input logic [15:0] idx, input logic [2:0] ex, input logic [3:0] dst);
    int n;
    cfg_we = 1'b1; cfg_index = idx; cfg_expect = ex; cfg_dst = dst;
    n = 0;
    while (!cfg_done && n < 20) begin tick(); n++; end
    cfg_we = 1'b0;
    vectors++;
    if (cfg_done !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_done_timeout idx=%0d: got %b want 1", idx, cfg_done);
    end
    tick();
    vectors++;
    if (cfg_done !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_done_pulse idx=%0d: got %b want 0", idx, cfg_done);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    tick(); tick();
    vectors++;
    if ({out_data, in_avail, cfg_done, err_unconfigured} !== 259'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got out=%h avail=%b done=%b err=%b want all 0",
               out_data, in_avail, cfg_done, err_unconfigured);
    end
    rst = 1'b1;
    n = 0;
    while (!in_avail && n < 400) begin tick(); n++; end
    vectors++;
    if (n !== 256) begin
      miscompares++;
      $display("FAIL init_cycles: got %0d want 256", n);
    end
  endtask

  task automatic test_unconfigured();
    logic [255:0] p;
    p = mkpkt(16'd3, 8'd7, 128'd77);
    in_data = p; tick(); in_data = '0; tick();
    vectors++;
    if (out_data !== p || err_unconfigured !== 1'b1) begin
      miscompares++;
      $display("FAIL unconf_pass: got out=%h err=%b want out=%h err=1", out_data, err_unconfigured, p);
    end
    tick();
    vectors++;
    if (out_data !== '0 || err_unconfigured !== 1'b0) begin
      miscompares++;
      $display("FAIL unconf_clear: got out=%h err=%b want 0", out_data, err_unconfigured);
    end
  endtask

  task automatic test_spaced();
    logic [127:0] pl [3];
    logic [255:0] exp_o;
    pl[0] = 128'd10; pl[1] = 128'd20; pl[2] = 128'd30;
    cfg_write(16'd5, 3'd3, 4'd2);
    for (int k = 0; k < 3; k++) begin
      in_data = mkpkt(16'd5, 8'd1, pl[k]); tick(); in_data = '0; tick();
      exp_o = (k == 2) ? mkout(16'd5, 8'd3, 128'd60, 4'd2) : '0;
      vectors++;
      if (out_data !== exp_o) begin
        miscompares++;
        $display("FAIL spaced_pkt%0d: got %h want %h", k, out_data, exp_o);
      end
      tick(); tick();
      vectors++;
      if (out_data !== '0) begin
        miscompares++;
        $display("FAIL spaced_idle%0d: got %h want 0", k, out_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] exp_o [5];
    exp_o[0] = '0; exp_o[1] = '0; exp_o[2] = '0;
    exp_o[3] = mkout(16'd5, 8'd9, 128'd600, 4'd2); exp_o[4] = '0;
    in_data = mkpkt(16'd5, 8'd2, 128'd100); tick();
    vectors++;
    if (out_data !== exp_o[0]) begin miscompares++; $display("FAIL b2b_t0: got %h want %h", out_data, exp_o[0]); end
    in_data = mkpkt(16'd5, 8'd3, 128'd200); tick();
    vectors++;
    if (out_data !== exp_o[1]) begin miscompares++; $display("FAIL b2b_t1: got %h want %h", out_data, exp_o[1]); end
    in_data = mkpkt(16'd5, 8'd4, 128'd300); tick();
    vectors++;
    if (out_data !== exp_o[2]) begin miscompares++; $display("FAIL b2b_t2: got %h want %h", out_data, exp_o[2]); end
    in_data = '0; tick();
    vectors++;
    if (out_data !== exp_o[3]) begin miscompares++; $display("FAIL b2b_t3: got %h want %h", out_data, exp_o[3]); end
    tick();
    vectors++;
    if (out_data !== exp_o[4]) begin miscompares++; $display("FAIL b2b_t4: got %h want %h", out_data, exp_o[4]); end
    // New round after clear: 7 + 8 + 9 = 24, weight 3
    in_data = mkpkt(16'd5, 8'd1, 128'd7); tick();
    in_data = mkpkt(16'd5, 8'd1, 128'd8); tick();
    in_data = mkpkt(16'd5, 8'd1, 128'd9); tick();
    in_data = '0; tick();
    vectors++;
    if (out_data !== mkout(16'd5, 8'd3, 128'd24, 4'd2)) begin
      miscompares++;
      $display("FAIL b2b_round2: got %h want %h", out_data, mkout(16'd5, 8'd3, 128'd24, 4'd2));
    end
    tick();
  endtask

  task automatic test_interleave();
    logic [255:0] seq   [4];
    logic [255:0] exp_o [6];
    cfg_write(16'd5, 3'd2, 4'd2);
    cfg_write(16'd9, 3'd2, 4'd4);
    seq[0] = mkpkt(16'd5, 8'd1,  128'd1);
    seq[1] = mkpkt(16'd9, 8'd10, 128'd1000);
    seq[2] = mkpkt(16'd5, 8'd2,  128'd2);
    seq[3] = mkpkt(16'd9, 8'd20, 128'd2000);
    exp_o[0] = '0; exp_o[1] = '0; exp_o[2] = '0;
    exp_o[3] = mkout(16'd5, 8'd3,  128'd3,    4'd2);
    exp_o[4] = mkout(16'd9, 8'd30, 128'd3000, 4'd4);
    exp_o[5] = '0;
    for (int t = 0; t < 6; t++) begin
      in_data = (t < 4) ? seq[t] : '0;
      tick();
      vectors++;
      if (out_data !== exp_o[t]) begin
        miscompares++;
        $display("FAIL interleave_t%0d: got %h want %h", t, out_data, exp_o[t]);
      end
    end
  endtask

  task automatic test_stall();
    logic [255:0] e1, e2;
    e1 = mkout(16'd5, 8'd2, 128'd11, 4'd2);
    e2 = mkout(16'd5, 8'd2, 128'd15, 4'd2);
    // Completing packet sits in AC while stalled
    in_data = mkpkt(16'd5, 8'd1, 128'd5); tick(); in_data = '0; tick(); tick();
    in_data = mkpkt(16'd5, 8'd1, 128'd6); tick(); in_data = '0;
    in_pipeline_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (out_data !== '0 || in_avail !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold_a%0d: got out=%h avail=%b want 0/0", k, out_data, in_avail);
      end
    end
    in_pipeline_stall = 1'b0; tick();
    vectors++;
    if (out_data !== e1) begin miscompares++; $display("FAIL stall_release_a: got %h want %h", out_data, e1); end
    tick();
    vectors++;
    if (out_data !== '0) begin miscompares++; $display("FAIL stall_once_a: got %h want 0", out_data); end
    // Completed packet on out_data held stable while stalled
    in_data = mkpkt(16'd5, 8'd1, 128'd7); tick();
    in_data = mkpkt(16'd5, 8'd1, 128'd8); tick(); in_data = '0; tick();
    in_pipeline_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (out_data !== e2) begin
        miscompares++;
        $display("FAIL stall_hold_b%0d: got %h want %h", k, out_data, e2);
      end
      tick();
    end
    in_pipeline_stall = 1'b0; tick();
    vectors++;
    if (out_data !== '0) begin miscompares++; $display("FAIL stall_once_b: got %h want 0", out_data); end
  endtask

  task automatic test_ignored();
    logic [255:0] p;
    cfg_write(16'd40, 3'd1, 4'd3);
    p = mkpkt(16'd40, 8'd5, 128'd50);
    p[254] = 1'b0;
    in_data = p; tick(); in_data = '0; tick();
    vectors++;
    if (out_data !== '0) begin miscompares++; $display("FAIL ignore_nonred: got %h want 0", out_data); end
    p = mkpkt(16'd40, 8'd5, 128'd50);
    p[255] = 1'b0;
    in_data = p; tick(); in_data = '0; tick();
    vectors++;
    if (out_data !== '0) begin miscompares++; $display("FAIL ignore_invalid: got %h want 0", out_data); end
    in_data = mkpkt(16'd40, 8'd5, 128'd50); tick(); in_data = '0; tick();
    vectors++;
    if (out_data !== mkout(16'd40, 8'd5, 128'd50, 4'd3)) begin
      miscompares++;
      $display("FAIL expect1_emit: got %h want %h", out_data, mkout(16'd40, 8'd5, 128'd50, 4'd3));
    end
    tick();
  endtask

  task automatic test_wrap();
    cfg_write(16'd20, 3'd2, 4'd1);
    in_data = mkpkt(16'd20, 8'd255, {128{1'b1}}); tick();
    in_data = mkpkt(16'd20, 8'd1, 128'd1); tick();
    in_data = '0; tick();
    vectors++;
    if (out_data !== mkout(16'd20, 8'd0, 128'd0, 4'd1)) begin
      miscompares++;
      $display("FAIL wrap: got %h want %h", out_data, mkout(16'd20, 8'd0, 128'd0, 4'd1));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    logic [255:0] p;
    cfg_write(16'd5, 3'd3, 4'd2);
    in_data = mkpkt(16'd5, 8'd1, 128'd1); tick();
    in_data = mkpkt(16'd30, 8'd1, 128'd1); tick(); in_data = '0; tick();
    vectors++;
    if (out_data !== mkpkt(16'd30, 8'd1, 128'd1)) begin
      miscompares++;
      $display("FAIL pre_reset_out: got %h want %h", out_data, mkpkt(16'd30, 8'd1, 128'd1));
    end
    rst = 1'b0; #2;
    vectors++;
    if ({out_data, in_avail, err_unconfigured} !== 258'd0) begin
      miscompares++;
      $display("FAIL async_reset: got out=%h avail=%b err=%b want 0", out_data, in_avail, err_unconfigured);
    end
    tick(); rst = 1'b1;
    for (int k = 0; k < 100; k++) tick();
    rst = 1'b0; tick(); rst = 1'b1;
    n = 0;
    while (!in_avail && n < 400) begin tick(); n++; end
    vectors++;
    if (n !== 256) begin miscompares++; $display("FAIL reinit_cycles: got %0d want 256", n); end
    p = mkpkt(16'd5, 8'd1, 128'd1);
    in_data = p; tick(); in_data = '0; tick();
    vectors++;
    if (out_data !== p || err_unconfigured !== 1'b1) begin
      miscompares++;
      $display("FAIL table_cleared: got out=%h err=%b want out=%h err=1", out_data, err_unconfigured, p);
    end
  endtask

  initial begin
    test_reset();
    test_unconfigured();
    test_spaced();
    test_back_to_back();
    test_interleave();
    test_stall();
    test_ignored();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
